// File: rtl/apb_slave_regbank.sv
// APB slave register bank: NUM_REGS x 32-bit registers, register 0 is a read-only ID,
// fixed WAIT_CYCLES wait states per access. Define APB_SLV_ERR_EN to drive pslverr.
module apb_slave_regbank #(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic [31:0] paddr,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  localparam int         IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               write_q, write_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               err_q, err_d;
  logic [31:0]        prdata_q, prdata_d;
  logic               pready_q, pready_d;
  logic               pslverr_q, pslverr_d;
  logic [31:0]        regs_q [NUM_REGS];
  logic [31:0]        regs_d [NUM_REGS];

  logic               complete_s;
  logic [IDX_W-1:0]   c_idx_s;
  logic               c_write_s;
  logic [31:0]        c_wdata_s;
  logic               c_err_s;

  // Misaligned, out-of-range, or a write aimed at the read-only ID register.
  function automatic logic decode_err(input logic [31:0] addr, input logic wr);
    logic misaligned;
    logic out_of_range;
    logic id_write;
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = ((addr >> (IDX_W + 2)) != 32'd0);
    id_write     = wr && (addr[IDX_W+1:2] == {IDX_W{1'b0}});
    return misaligned || out_of_range || id_write;
  endfunction

  // Transfer sequencing, register update and next output values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    prdata_d   = 32'd0;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    regs_d     = regs_q;
    complete_s = 1'b0;
    c_idx_s    = idx_q;
    c_write_s  = write_q;
    c_wdata_s  = wdata_q;
    c_err_s    = err_q;

    case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          idx_d   = paddr[IDX_W+1:2];
          write_d = pwrite;
          wdata_d = pwdata;
          err_d   = decode_err(paddr, pwrite);
          cnt_d   = WAIT_LD;
          if (WAIT_LD == 4'd0) begin
            // Zero wait states: complete straight from the live setup-phase inputs.
            complete_s = 1'b1;
            c_idx_s    = paddr[IDX_W+1:2];
            c_write_s  = pwrite;
            c_wdata_s  = pwdata;
            c_err_s    = decode_err(paddr, pwrite);
            state_d    = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!psel) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (penable) begin
          if (cnt_q <= 4'd1) begin
            complete_s = 1'b1;
            cnt_d      = 4'd0;
            state_d    = S_DONE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (complete_s) begin
      pready_d = 1'b1;
      if (c_write_s) begin
        if (!c_err_s) begin
          regs_d[c_idx_s] = c_wdata_s;
        end else begin
          regs_d = regs_q;
        end
      end else if (!c_err_s) begin
        prdata_d = (c_idx_s == {IDX_W{1'b0}}) ? ID_VALUE : regs_q[c_idx_s];
      end else begin
        prdata_d = 32'd0;
      end
`ifdef APB_SLV_ERR_EN
      pslverr_d = c_err_s;
`else
      pslverr_d = 1'b0;
`endif
    end else begin
      pready_d = 1'b0;
    end
  end

  // State, latched transfer, register file and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= {IDX_W{1'b0}};
      write_q   <= 1'b0;
      wdata_q   <= 32'd0;
      err_q     <= 1'b0;
      prdata_q  <= 32'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      regs_q    <= regs_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Scoreboard bench for apb_slave_regbank: one instance with 2 wait states, one with none.
module tb_apb_slave_regbank;

  localparam logic [31:0] ID = 32'hA5B0_0001;
`ifdef APB_SLV_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  psel = 2'b00, penable = 2'b00, pwrite = 2'b00;
  logic [31:0] paddr0 = 32'd0, paddr1 = 32'd0, pwdata0 = 32'd0, pwdata1 = 32'd0;
  wire  [31:0] prdata0, prdata1;
  wire         pready0, pready1, pslverr0, pslverr1;

  typedef struct {
    logic        is_rd;
    logic [31:0] rdata;
    logic        slverr;
    int          low;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  apb_slave_regbank #(.NUM_REGS(16), .WAIT_CYCLES(2), .ID_VALUE(ID)) dut (
    .clk(clk), .rst(rst), .psel(psel[0]), .penable(penable[0]), .paddr(paddr0),
    .pwrite(pwrite[0]), .pwdata(pwdata0), .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0));

  apb_slave_regbank #(.NUM_REGS(16), .WAIT_CYCLES(0), .ID_VALUE(ID)) dut_w0 (
    .clk(clk), .rst(rst), .psel(psel[1]), .penable(penable[1]), .paddr(paddr1),
    .pwrite(pwrite[1]), .pwdata(pwdata1), .prdata(prdata1), .pready(pready1),
    .pslverr(pslverr1));

  task automatic drive(input int w, input logic s, input logic e, input logic [31:0] a,
                       input logic wr, input logic [31:0] d);
    if (w == 0) begin
      psel[0] = s; penable[0] = e; paddr0 = a; pwrite[0] = wr; pwdata0 = d;
    end else begin
      psel[1] = s; penable[1] = e; paddr1 = a; pwrite[1] = wr; pwdata1 = d;
    end
  endtask

  task automatic bus_idle(input int w);
    @(posedge clk); #1;
    drive(w, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  // One full transfer; returns at the negedge where pready was seen high.
  task automatic xfer(input int w, input logic [31:0] a, input logic wr, input logic [31:0] d,
                      output logic [31:0] rd, output logic se, output int low, output bit to);
    @(posedge clk); #1;
    drive(w, 1'b1, 1'b0, a, wr, d);
    @(posedge clk); #1;
    drive(w, 1'b1, 1'b1, a, wr, d);
    low = 0; to = 1'b1; rd = 32'd0; se = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (((w == 0) ? pready0 : pready1) === 1'b1) begin
        rd = (w == 0) ? prdata0 : prdata1;
        se = (w == 0) ? pslverr0 : pslverr1;
        to = 1'b0;
        break;
      end
      low++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic se; int low; bit to; exp_t e;
    repeat (3) @(negedge clk);
    n_cmp++; if (pready0 !== 1'b0 || pslverr0 !== 1'b0 || prdata0 !== 32'd0) begin
      n_bad++; $display("FAIL reset_out0 got pready=%b pslverr=%b prdata=%h want 0/0/0", pready0, pslverr0, prdata0);
    end
    n_cmp++; if (pready1 !== 1'b0 || pslverr1 !== 1'b0 || prdata1 !== 32'd0) begin
      n_bad++; $display("FAIL reset_out1 got pready=%b pslverr=%b prdata=%h want 0/0/0", pready1, pslverr1, prdata1);
    end
    rst = 1'b1;
    sb.push_back('{1'b1, ID, 1'b0, 2});
    xfer(0, 32'h0, 1'b0, 32'd0, rd, se, low, to);
    e = sb.pop_front();
    n_cmp++; if (to) begin n_bad++; $display("FAIL reset_id timeout"); end
    n_cmp++; if (rd !== e.rdata) begin n_bad++; $display("FAIL reset_id prdata got %h want %h", rd, e.rdata); end
    n_cmp++; if (se !== e.slverr) begin n_bad++; $display("FAIL reset_id pslverr got %b want %b", se, e.slverr); end
    n_cmp++; if (low !== e.low) begin n_bad++; $display("FAIL reset_id wait got %0d want %0d", low, e.low); end
    bus_idle(0);
  endtask

  task automatic test_rw();
    logic [31:0] a_t[6] = '{32'h8, 32'h8, 32'h3C, 32'h3C, 32'h4, 32'h4};
    logic        w_t[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] d_t[6] = '{32'hDEAD_BEEF, 32'd0, 32'h1234_5678, 32'd0, 32'hCAFE_0004, 32'd0};
    logic [31:0] x_t[6] = '{32'd0, 32'hDEAD_BEEF, 32'd0, 32'h1234_5678, 32'd0, 32'hCAFE_0004};
    logic [31:0] rd; logic se; int low; bit to; exp_t e;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{!w_t[i], x_t[i], 1'b0, 2});
      xfer(0, a_t[i], w_t[i], d_t[i], rd, se, low, to);
      e = sb.pop_front();
      n_cmp++; if (to) begin n_bad++; $display("FAIL rw[%0d] timeout", i); end
      n_cmp++; if (se !== e.slverr) begin n_bad++; $display("FAIL rw[%0d] pslverr got %b want %b", i, se, e.slverr); end
      n_cmp++; if (low !== e.low) begin n_bad++; $display("FAIL rw[%0d] wait got %0d want %0d", i, low, e.low); end
      if (e.is_rd) begin
        n_cmp++; if (rd !== e.rdata) begin n_bad++; $display("FAIL rw[%0d] prdata got %h want %h", i, rd, e.rdata); end
      end
    end
    // pready lasts one cycle; penable left high in IDLE must not start a transfer.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++; if (pready0 !== 1'b0) begin n_bad++; $display("FAIL rw_pready_drop[%0d] got %b want 0", k, pready0); end
    end
    bus_idle(0);
  endtask

  task automatic test_errors();
    logic [31:0] a_t[8] = '{32'h0, 32'h42, 32'h40, 32'hA, 32'h42, 32'h0, 32'h8, 32'h3C};
    logic        w_t[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        e_t[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] x_t[8] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, ID, 32'hDEAD_BEEF, 32'h1234_5678};
    logic [31:0] rd; logic se; int low; bit to; exp_t e;
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{!w_t[i], x_t[i], e_t[i] & ERR_ON, 2});
      xfer(0, a_t[i], w_t[i], 32'h5555_5555, rd, se, low, to);
      e = sb.pop_front();
      n_cmp++; if (to) begin n_bad++; $display("FAIL err[%0d] timeout", i); end
      n_cmp++; if (se !== e.slverr) begin n_bad++; $display("FAIL err[%0d] pslverr got %b want %b", i, se, e.slverr); end
      n_cmp++; if (low !== e.low) begin n_bad++; $display("FAIL err[%0d] wait got %0d want %0d", i, low, e.low); end
      if (e.is_rd) begin
        n_cmp++; if (rd !== e.rdata) begin n_bad++; $display("FAIL err[%0d] prdata got %h want %h", i, rd, e.rdata); end
      end
    end
    bus_idle(0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_t[5] = '{32'h4, 32'hC, 32'h4, 32'hC, 32'h0};
    logic        w_t[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] d_t[5] = '{32'hA1A1_0004, 32'hB2B2_000C, 32'd0, 32'd0, 32'd0};
    logic [31:0] x_t[5] = '{32'd0, 32'd0, 32'hA1A1_0004, 32'hB2B2_000C, ID};
    logic [31:0] rd; logic se; int low; bit to; exp_t e;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{!w_t[i], x_t[i], 1'b0, 0});
      xfer(1, a_t[i], w_t[i], d_t[i], rd, se, low, to);
      e = sb.pop_front();
      n_cmp++; if (to) begin n_bad++; $display("FAIL b2b[%0d] timeout", i); end
      n_cmp++; if (se !== e.slverr) begin n_bad++; $display("FAIL b2b[%0d] pslverr got %b want %b", i, se, e.slverr); end
      n_cmp++; if (low !== e.low) begin n_bad++; $display("FAIL b2b[%0d] wait got %0d want %0d", i, low, e.low); end
      if (e.is_rd) begin
        n_cmp++; if (rd !== e.rdata) begin n_bad++; $display("FAIL b2b[%0d] prdata got %h want %h", i, rd, e.rdata); end
      end
    end
    bus_idle(1);
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic se; int low; bit to; exp_t e;
    @(posedge clk); #1; drive(0, 1'b1, 1'b0, 32'h4, 1'b1, 32'h1111_1111);
    @(posedge clk); #1; drive(0, 1'b1, 1'b1, 32'h4, 1'b1, 32'h1111_1111);
    @(posedge clk); #1; drive(0, 1'b0, 1'b0, 32'h4, 1'b1, 32'h1111_1111);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (pready0 !== 1'b0) begin n_bad++; $display("FAIL abort_pready[%0d] got %b want 0", k, pready0); end
    end
    sb.push_back('{1'b1, 32'hCAFE_0004, 1'b0, 2});
    xfer(0, 32'h4, 1'b0, 32'd0, rd, se, low, to);
    e = sb.pop_front();
    n_cmp++; if (to) begin n_bad++; $display("FAIL abort_read timeout"); end
    n_cmp++; if (rd !== e.rdata) begin n_bad++; $display("FAIL abort_read prdata got %h want %h", rd, e.rdata); end
    bus_idle(0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] a_t[3] = '{32'h14, 32'h8, 32'h0};
    logic [31:0] x_t[3] = '{32'd0, 32'd0, ID};
    logic [31:0] rd; logic se; int low; bit to; exp_t e;
    // Reset while the completion cycle is presenting non-zero read data.
    sb.push_back('{1'b1, 32'hDEAD_BEEF, 1'b0, 2});
    xfer(0, 32'h8, 1'b0, 32'd0, rd, se, low, to);
    e = sb.pop_front();
    n_cmp++; if (rd !== e.rdata || to) begin n_bad++; $display("FAIL rstmid_pre prdata got %h want %h", rd, e.rdata); end
    rst = 1'b0; #1;
    n_cmp++; if (pready0 !== 1'b0 || prdata0 !== 32'd0 || pslverr0 !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_done got pready=%b prdata=%h pslverr=%b want 0/0/0", pready0, prdata0, pslverr0);
    end
    drive(0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge clk); rst = 1'b1;
    // Reset while a write is waiting.
    @(posedge clk); #1; drive(0, 1'b1, 1'b0, 32'h14, 1'b1, 32'h7777_7777);
    @(posedge clk); #1; drive(0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h7777_7777);
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++; if (pready0 !== 1'b0 || prdata0 !== 32'd0 || pslverr0 !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_wait got pready=%b prdata=%h pslverr=%b want 0/0/0", pready0, prdata0, pslverr0);
    end
    drive(0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{1'b1, x_t[i], 1'b0, 2});
      xfer(0, a_t[i], 1'b0, 32'd0, rd, se, low, to);
      e = sb.pop_front();
      n_cmp++; if (to) begin n_bad++; $display("FAIL rstmid_rd[%0d] timeout", i); end
      n_cmp++; if (rd !== e.rdata) begin n_bad++; $display("FAIL rstmid_rd[%0d] prdata got %h want %h", i, rd, e.rdata); end
    end
    bus_idle(0);
  endtask

  initial begin
    test_reset();
    test_rw();
    test_errors();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
